// File: rtl/cache_control_pkg.sv
// Shared types and address-split helpers for the 2-way set-associative L1 cache controller.
package cache_control_pkg;

  localparam int NUM_SETS = 16;
  localparam int TAG_W    = 8;
  localparam int SET_W    = 4;
  localparam int OFF_W    = 4;
  localparam int ADDR_W   = TAG_W + SET_W + OFF_W;

  typedef logic [TAG_W-1:0]  lc3b_tag;
  typedef logic [SET_W-1:0]  lc3b_set;
  typedef logic [OFF_W-1:0]  lc3b_offset;
  typedef logic [ADDR_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  function automatic lc3b_tag addr_tag(input lc3b_word addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic lc3b_set addr_set(input lc3b_word addr);
    return addr[OFF_W +: SET_W];
  endfunction

  function automatic lc3b_offset addr_offset(input lc3b_word addr);
    return addr[OFF_W-1:0];
  endfunction

  function automatic lc3b_word line_addr(input lc3b_tag tag, input lc3b_set set);
    return {tag, set, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_control_meta_array.sv
// Per-set valid/dirty/LRU bits for both ways; async-clear flops with per-set write enables.
module cache_meta_array
  import cache_control_pkg::*;
#(
  parameter int NUM_SETS = cache_control_pkg::NUM_SETS,
  parameter int SET_W    = cache_control_pkg::SET_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] set_i,
  input  logic             lru_we_i,
  input  logic             lru_val_i,
  input  logic             dirty_we_i,
  input  logic             dirty_way_i,
  input  logic             dirty_val_i,
  input  logic             fill_we_i,
  input  logic             fill_way_i,
  output logic [1:0]       valid_o,
  output logic [1:0]       dirty_o,
  output logic             lru_o
);

  logic [NUM_SETS-1:0] valid0_q, valid0_d;
  logic [NUM_SETS-1:0] valid1_q, valid1_d;
  logic [NUM_SETS-1:0] dirty0_q, dirty0_d;
  logic [NUM_SETS-1:0] dirty1_q, dirty1_d;
  logic [NUM_SETS-1:0] lru_q,    lru_d;

  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    dirty0_d = dirty0_q;
    dirty1_d = dirty1_q;
    lru_d    = lru_q;
    // A fill always leaves the freshly loaded line clean.
    if (fill_we_i) begin
      if (fill_way_i) begin
        valid1_d[set_i] = 1'b1;
        dirty1_d[set_i] = 1'b0;
      end else begin
        valid0_d[set_i] = 1'b1;
        dirty0_d[set_i] = 1'b0;
      end
    end
    if (dirty_we_i) begin
      if (dirty_way_i) dirty1_d[set_i] = dirty_val_i;
      else             dirty0_d[set_i] = dirty_val_i;
    end
    if (lru_we_i) lru_d[set_i] = lru_val_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= '0;
      valid1_q <= '0;
      dirty0_q <= '0;
      dirty1_q <= '0;
      lru_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      dirty0_q <= dirty0_d;
      dirty1_q <= dirty1_d;
      lru_q    <= lru_d;
    end
  end

  assign valid_o = {valid1_q[set_i], valid0_q[set_i]};
  assign dirty_o = {dirty1_q[set_i], dirty0_q[set_i]};
  assign lru_o   = lru_q[set_i];

endmodule

// File: rtl/cache_control.sv
// Hit/miss controller for the 2-way L1: tag compare, LRU/dirty upkeep, writeback/allocate sequencing.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int NUM_SETS = cache_control_pkg::NUM_SETS,
  parameter int TAG_W    = cache_control_pkg::TAG_W,
  parameter int SET_W    = cache_control_pkg::SET_W,
  parameter int OFF_W    = cache_control_pkg::OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_address,
  input  logic [TAG_W-1:0] tag_out0,
  input  logic [TAG_W-1:0] tag_out1,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             tag_load,
  output logic             way_sel,
  output logic             data_load,
  output logic             data_write,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [15:0]      pmem_address
);

  cache_state_t state_q, state_d;
  logic         victim_q, victim_d;

  lc3b_tag    req_tag;
  lc3b_set    req_set;
  lc3b_offset unused_off;
  logic       req, hit0, hit1, hit, hit_way;
  logic [1:0] valid_w, dirty_w;
  logic       lru_w;
  lc3b_tag    victim_tag;

  logic lru_we, lru_val, dirty_we, dirty_way, dirty_val, fill_we;

  assign req_tag    = addr_tag(mem_address);
  assign req_set    = addr_set(mem_address);
  assign unused_off = addr_offset(mem_address);
  assign req        = mem_read | mem_write;

  // Both ways matching means corrupt state; way 0 takes priority.
  assign hit0       = valid_w[0] & (tag_out0 == req_tag);
  assign hit1       = valid_w[1] & (tag_out1 == req_tag);
  assign hit        = hit0 | hit1;
  assign hit_way    = ~hit0;
  assign victim_tag = victim_q ? tag_out1 : tag_out0;

  cache_meta_array #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) u_meta (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (req_set),
    .lru_we_i    (lru_we),
    .lru_val_i   (lru_val),
    .dirty_we_i  (dirty_we),
    .dirty_way_i (dirty_way),
    .dirty_val_i (dirty_val),
    .fill_we_i   (fill_we),
    .fill_way_i  (victim_q),
    .valid_o     (valid_w),
    .dirty_o     (dirty_w),
    .lru_o       (lru_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    tag_load     = 1'b0;
    way_sel      = 1'b0;
    data_load    = 1'b0;
    data_write   = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    dirty_we     = 1'b0;
    dirty_way    = 1'b0;
    dirty_val    = 1'b0;
    fill_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          lru_we   = 1'b1;
          lru_val  = ~hit_way;
          // A simultaneous read+write is handled as a write.
          if (mem_write) begin
            data_write = 1'b1;
            dirty_we   = 1'b1;
            dirty_way  = hit_way;
            dirty_val  = 1'b1;
          end
        end else if (req) begin
          victim_d = lru_w;
          state_d  = (valid_w[lru_w] && dirty_w[lru_w]) ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(victim_tag, req_set);
        way_sel      = victim_q;
        if (pmem_resp) begin
          dirty_we  = 1'b1;
          dirty_way = victim_q;
          dirty_val = 1'b0;
          // An abandoned request stops after the writeback completes.
          state_d   = req ? ALLOCATE : IDLE;
        end
      end

      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(req_tag, req_set);
        way_sel      = victim_q;
        if (pmem_resp) begin
          tag_load  = 1'b1;
          data_load = 1'b1;
          fill_we   = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control with a behavioural cache model and tag_array stand-in.
module tb_cache_control;

  localparam logic [1:0] EV_RESP = 2'd0;
  localparam logic [1:0] EV_WB   = 2'd1;
  localparam logic [1:0] EV_FILL = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic        way;
    logic        flag;
    logic        post_fill;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic [7:0]  tag_out0, tag_out1;
  logic        pmem_resp;
  logic        mem_resp, tag_load, way_sel, data_load, data_write;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fill_cyc = -10;
  bit sb_en  = 1'b0;
  bit mem_en = 1'b0;
  ev_t exp_q[$];

  // environment tag_array (not reset)
  logic [7:0] tarr0 [16];
  logic [7:0] tarr1 [16];

  // reference model state
  bit       mv [2][16];
  bit       md [2][16];
  bit       mlru [16];
  bit [7:0] mt [2][16];

  cache_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .tag_out0     (tag_out0),
    .tag_out1     (tag_out1),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .tag_load     (tag_load),
    .way_sel      (way_sel),
    .data_load    (data_load),
    .data_write   (data_write),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tag_out0 = tarr0[mem_address[7:4]];
  assign tag_out1 = tarr1[mem_address[7:4]];

  always @(posedge clk) begin
    if (tag_load) begin
      if (way_sel) tarr1[mem_address[7:4]] <= mem_address[15:8];
      else         tarr0[mem_address[7:4]] <= mem_address[15:8];
    end
  end

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        mv[w][s] = 1'b0;
        md[w][s] = 1'b0;
        mlru[s]  = 1'b0;
      end
  endtask

  // Expected externally visible events for one request, from cache rules.
  task automatic model_issue(input logic [15:0] a, input bit is_wr);
    bit [7:0] t;
    int  s;
    bit  v;
    ev_t e;
    t = a[15:8];
    s = int'(a[7:4]);
    if (mv[0][s] && mt[0][s] == t) v = 1'b0;
    else if (mv[1][s] && mt[1][s] == t) v = 1'b1;
    else begin
      v = mlru[s];
      if (mv[v][s] && md[v][s]) begin
        e = '{kind: EV_WB, addr: {mt[v][s], a[7:4], 4'h0}, way: v, flag: 1'b0, post_fill: 1'b0};
        exp_q.push_back(e);
        md[v][s] = 1'b0;
      end
      e = '{kind: EV_FILL, addr: {t, a[7:4], 4'h0}, way: v, flag: 1'b1, post_fill: 1'b0};
      exp_q.push_back(e);
      mv[v][s] = 1'b1;
      mt[v][s] = t;
      md[v][s] = 1'b0;
      e = '{kind: EV_RESP, addr: 16'h0, way: v, flag: is_wr, post_fill: 1'b1};
      exp_q.push_back(e);
      mlru[s] = ~v;
      if (is_wr) md[v][s] = 1'b1;
      return;
    end
    e = '{kind: EV_RESP, addr: 16'h0, way: v, flag: is_wr, post_fill: 1'b0};
    exp_q.push_back(e);
    mlru[s] = ~v;
    if (is_wr) md[v][s] = 1'b1;
  endtask

  task automatic do_req(input logic [15:0] a, input bit rd, input bit wr);
    bit got;
    model_issue(a, wr);
    mem_address = a;
    mem_read    = rd;
    mem_write   = wr;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout addr=%h: got no mem_resp, required one within 80 cycles", a);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic compare_ev(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h way=%0d flag=%0d, required none",
               got.kind, got.addr, got.way, got.flag);
      return;
    end
    e = exp_q.pop_front();
    if (got.kind != e.kind || got.addr != e.addr || got.way != e.way || got.flag != e.flag) begin
      errors++;
      $display("FAIL event: got kind=%0d addr=%h way=%0d flag=%0d, required kind=%0d addr=%h way=%0d flag=%0d",
               got.kind, got.addr, got.way, got.flag, e.kind, e.addr, e.way, e.flag);
    end
    if (got.kind == EV_RESP && e.kind == EV_RESP && e.post_fill) begin
      checks++;
      if (cyc != fill_cyc + 1) begin
        errors++;
        $display("FAIL fill_to_resp: got %0d cycles, required 1", cyc - fill_cyc);
      end
    end
  endtask

  // Monitor: turns DUT activity into events and checks them against the scoreboard.
  initial begin
    ev_t o;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        checks++;
        if ((pmem_read && pmem_write) || (data_write && !mem_resp) ||
            (mem_resp && (pmem_read || pmem_write)) || (tag_load && !(pmem_read && pmem_resp))) begin
          errors++;
          $display("FAIL protocol: pr=%0b pw=%0b resp=%0b dw=%0b tl=%0b, required exclusive/legal combination",
                   pmem_read, pmem_write, mem_resp, data_write, tag_load);
        end
        if (mem_resp) begin
          o = '{kind: EV_RESP, addr: 16'h0, way: way_sel, flag: data_write, post_fill: 1'b0};
          compare_ev(o);
        end
        if (pmem_resp && pmem_write) begin
          o = '{kind: EV_WB, addr: pmem_address, way: way_sel, flag: 1'b0, post_fill: 1'b0};
          compare_ev(o);
        end
        if (pmem_resp && pmem_read) begin
          o = '{kind: EV_FILL, addr: pmem_address, way: way_sel, flag: tag_load & data_load, post_fill: 1'b0};
          compare_ev(o);
          fill_cyc = cyc;
        end
      end
    end
  end

  // Physical memory responder: one-cycle pmem_resp after a random latency.
  initial begin
    pmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en && rst_n && (pmem_read || pmem_write)) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
      end
    end
  end

  initial begin
    bit seen;
    int sel;
    logic [7:0] tags [4];
    logic [15:0] a;
    tags[0] = 8'h12; tags[1] = 8'h45; tags[2] = 8'h78; tags[3] = 8'h9A;
    for (int s = 0; s < 16; s++) begin
      tarr0[s] = 8'($urandom);
      tarr1[s] = 8'($urandom);
    end
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 16'h1230;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_resp, tag_load, way_sel, data_load, data_write, pmem_read, pmem_write} != 7'b0 || pmem_address != 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h, required all zero",
               {mem_resp, tag_load, way_sel, data_load, data_write, pmem_read, pmem_write}, pmem_address);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    sb_en  = 1'b1;
    mem_en = 1'b1;

    do_req(16'h1230, 1'b1, 1'b0);

    // Reset asserted in the middle of an allocate.
    repeat (3) @(posedge clk);
    #1;
    sb_en  = 1'b0;
    mem_en = 1'b0;
    mem_address = 16'h5630;
    mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || pmem_address != 16'h5630 || way_sel != 1'b1) begin
      errors++;
      $display("FAIL mid_alloc: got seen=%0b addr=%h way=%0d, required 1/5630/1", seen, pmem_address, way_sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_resp, tag_load, data_load, data_write, pmem_read, pmem_write} != 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, required 000000",
               {mem_resp, tag_load, data_load, data_write, pmem_read, pmem_write});
    end
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    sb_en  = 1'b1;
    mem_en = 1'b1;

    // Directed sequence on set 3.
    do_req(16'h1230, 1'b1, 1'b0);
    do_req(16'h4530, 1'b1, 1'b0);
    do_req(16'h1230, 1'b1, 1'b0);
    do_req(16'h4530, 1'b1, 1'b0);
    do_req(16'h1232, 1'b0, 1'b1);
    do_req(16'h4530, 1'b1, 1'b0);
    do_req(16'h7830, 1'b1, 1'b0);
    do_req(16'h7834, 1'b1, 1'b1);
    do_req(16'h4530, 1'b0, 1'b1);
    do_req(16'h1230, 1'b1, 1'b0);

    // Randomized traffic over a few sets and tags to force conflicts.
    for (int n = 0; n < 250; n++) begin
      a[15:8] = tags[$urandom_range(0, 3)];
      a[7:4]  = 4'($urandom_range(0, 3));
      a[3:0]  = 4'($urandom);
      sel = int'($urandom_range(0, 2));
      do_req(a, sel != 1, sel != 0);
    end

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected events, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
